pio_gpio_ctrl: RTL and testbench

Parametrised Avalon-MM general-purpose I/O slave for the Nios II system. Provides per-bit direction control and atomic set/clear of output bits. Input pins pass through a synchroniser and feed per-bit edge capture, which drives a maskable level interrupt. Pad tristating happens at top level using out_port/out_oe; in_port comes back from the pads.

---
 rtl/pio_gpio_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pio_gpio_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_gpio_ctrl.sv
// pio_gpio_ctrl: Avalon-MM GPIO slave with per-bit direction, atomic set/clear,
// synchronised inputs, per-bit edge capture and a maskable level irq.
// Optional macro PIO_INSYNC_EN selects a 2-flop input synchroniser (default: single flop).
module pio_gpio_ctrl #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter logic [31:0] RESET_OUT  = 32'd0,
  parameter logic [31:0] RESET_DIR  = 32'd0,
  parameter int unsigned EDGE_TYPE  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_oe,
  output logic                  irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam logic [DATA_WIDTH-1:0] RST_OUT  = RESET_OUT[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] RST_DIR  = RESET_DIR[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] ALL_ZERO = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] data_out_r;
  logic [DATA_WIDTH-1:0] dir_r;
  logic [DATA_WIDTH-1:0] irqmask_r;
  logic [DATA_WIDTH-1:0] edgecap_r;
  logic [DATA_WIDTH-1:0] in_q_r;
  logic [DATA_WIDTH-1:0] in_prev_r;
  logic [DATA_WIDTH-1:0] edge_s;
  logic [DATA_WIDTH-1:0] cap_clr_s;
  logic                  wr_s;
  logic                  unused_read_s;

  // Per-bit edge detector selected at elaboration time by EDGE_TYPE.
  function automatic logic [DATA_WIDTH-1:0] edge_detect(
    input logic [DATA_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] prev
  );
    logic [DATA_WIDTH-1:0] res;
    case (EDGE_TYPE)
      32'd0:   res = cur & ~prev;
      32'd1:   res = ~cur & prev;
      default: res = cur ^ prev;
    endcase
    return res;
  endfunction

  // Reads have no side effects, so the read strobe carries no information here.
  assign unused_read_s = read_n;
  assign wr_s          = chipselect & ~write_n;

`ifdef PIO_INSYNC_EN
  logic [DATA_WIDTH-1:0] in_meta_r;

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_meta_r <= ALL_ZERO;
      in_q_r    <= ALL_ZERO;
    end else begin
      in_meta_r <= in_port;
      in_q_r    <= in_meta_r;
    end
  end
`else
  // Single input register for the pad inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q_r <= ALL_ZERO;
    end else begin
      in_q_r <= in_port;
    end
  end
`endif

  // Previous-sample register for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_prev_r <= ALL_ZERO;
    end else begin
      in_prev_r <= in_q_r;
    end
  end

  // Edge detect and write-1-to-clear mask for the capture register.
  always_comb begin
    edge_s    = edge_detect(in_q_r, in_prev_r);
    cap_clr_s = ALL_ZERO;
    if (wr_s && (address == ADDR_EDGECAP)) begin
      cap_clr_s = writedata;
    end else begin
      cap_clr_s = ALL_ZERO;
    end
  end

  // Output data register with full load, atomic set and atomic clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= RST_OUT;
    end else if (wr_s) begin
      case (address)
        ADDR_DATA:   data_out_r <= writedata;
        ADDR_OUTSET: data_out_r <= data_out_r | writedata;
        ADDR_OUTCLR: data_out_r <= data_out_r & ~writedata;
        default:     data_out_r <= data_out_r;
      endcase
    end else begin
      data_out_r <= data_out_r;
    end
  end

  // Direction and interrupt mask registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_r     <= RST_DIR;
      irqmask_r <= ALL_ZERO;
    end else if (wr_s) begin
      case (address)
        ADDR_DIR:     dir_r     <= writedata;
        ADDR_IRQMASK: irqmask_r <= writedata;
        default: begin
          dir_r     <= dir_r;
          irqmask_r <= irqmask_r;
        end
      endcase
    end else begin
      dir_r     <= dir_r;
      irqmask_r <= irqmask_r;
    end
  end

  // Edge capture: a new edge takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap_r <= ALL_ZERO;
    end else begin
      edgecap_r <= (edgecap_r & ~cap_clr_s) | edge_s;
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    readdata = ALL_ZERO;
    case (address)
      ADDR_DATA:    readdata = (data_out_r & dir_r) | (in_q_r & ~dir_r);
      ADDR_DIR:     readdata = dir_r;
      ADDR_IRQMASK: readdata = irqmask_r;
      ADDR_EDGECAP: readdata = edgecap_r;
      default:      readdata = ALL_ZERO;
    endcase
  end

  assign out_port = data_out_r;
  assign out_oe   = dir_r;
  assign irq      = |(edgecap_r & irqmask_r);

endmodule

// File: tb/tb_pio_gpio_ctrl.sv
// Self-checking bench for pio_gpio_ctrl: directed scenarios plus randomized bus and pin
// traffic compared against a cycle-level behavioural model of the register map.
module tb_pio_gpio_ctrl;

  localparam int W = 11;
  localparam int EDGE_TYPE = 0;
`ifdef PIO_INSYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   address = 3'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic         read_n = 1'b1;
  logic [W-1:0] writedata = '0;
  logic [W-1:0] readdata;
  logic [W-1:0] in_port = '0;
  logic [W-1:0] out_port;
  logic [W-1:0] out_oe;
  logic         irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model state; samp[k] is in_port as sampled k+1 edges ago.
  logic [W-1:0] m_dout, m_dir, m_mask, m_cap;
  logic [W-1:0] samp [0:2];

  pio_gpio_ctrl #(.DATA_WIDTH(W), .RESET_OUT(32'd0), .RESET_DIR(32'd0), .EDGE_TYPE(EDGE_TYPE)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .out_oe(out_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return (m_dout & m_dir) | (samp[LAT-1] & ~m_dir);
      3'd1:    return m_dir;
      3'd2:    return m_mask;
      3'd3:    return m_cap;
      default: return '0;
    endcase
  endfunction

  function automatic logic m_irq();
    return |(m_cap & m_mask);
  endfunction

  task automatic model_reset();
    m_dout = '0; m_dir = '0; m_mask = '0; m_cap = '0;
    for (int i = 0; i < 3; i++) samp[i] = '0;
  endtask

  // Advance the model by one clock using the current inputs, then step the DUT.
  task automatic tick();
    logic [W-1:0] q, p, ed, clr;
    q = samp[LAT-1];
    p = samp[LAT];
    if (EDGE_TYPE == 0) ed = q & ~p;
    else if (EDGE_TYPE == 1) ed = ~q & p;
    else ed = q ^ p;
    clr = '0;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: m_dout = writedata;
        3'd1: m_dir = writedata;
        3'd2: m_mask = writedata;
        3'd3: clr = writedata;
        3'd4: m_dout = m_dout | writedata;
        3'd5: m_dout = m_dout & ~writedata;
        default: ;
      endcase
    end
    m_cap = (m_cap & ~clr) | ed;
    samp[2] = samp[1];
    samp[1] = samp[0];
    samp[0] = in_port;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [W-1:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    #12;
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 8; a++) begin
      address = a[2:0];
      #1;
      checks++;
      if (readdata !== 11'h000) begin
        $display("FAIL reset_read addr=%0d got=%h exp=%h", a, readdata, 11'h000);
        errors++;
      end
    end
    checks++;
    if (out_port !== 11'h000 || out_oe !== 11'h000 || irq !== 1'b0) begin
      $display("FAIL reset_outputs out_port=%h out_oe=%h irq=%b exp 000/000/0", out_port, out_oe, irq);
      errors++;
    end
  endtask

  task automatic test_set_clr();
    bus_write(3'd1, 11'h7FF);
    bus_write(3'd0, 11'h0F0);
    bus_write(3'd4, 11'h003);
    checks++;
    if (out_port !== 11'h0F3 || out_port !== m_dout) begin
      $display("FAIL outset got=%h exp=%h", out_port, 11'h0F3);
      errors++;
    end
    bus_write(3'd5, 11'h010);
    checks++;
    if (out_port !== 11'h0E3) begin
      $display("FAIL outclr got=%h exp=%h", out_port, 11'h0E3);
      errors++;
    end
    address = 3'd0; #1;
    checks++;
    if (readdata !== 11'h0E3 || out_oe !== 11'h7FF) begin
      $display("FAIL data_readback got=%h oe=%h exp=0e3/7ff", readdata, out_oe);
      errors++;
    end
    for (int a = 4; a < 8; a++) begin
      address = a[2:0]; #1;
      checks++;
      if (readdata !== 11'h000) begin
        $display("FAIL wo_read addr=%0d got=%h exp=000", a, readdata);
        errors++;
      end
    end
  endtask

  task automatic test_input();
    bus_write(3'd1, 11'h000);
    in_port = 11'h555;
    address = 3'd0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      checks++;
      if (readdata !== m_read(3'd0) || (k == LAT && readdata !== 11'h555) || (k < LAT && readdata === 11'h555)) begin
        $display("FAIL input_latency cycle=%0d got=%h exp=%h", k, readdata, m_read(3'd0));
        errors++;
      end
    end
  endtask

  task automatic test_edge_irq();
    in_port = '0;
    repeat (LAT + 2) tick();
    bus_write(3'd3, 11'h7FF);
    bus_write(3'd2, 11'h001);
    in_port = 11'h001;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      checks++;
      if (irq !== m_irq() || irq !== (k == LAT + 1)) begin
        $display("FAIL irq_latency cycle=%0d got=%b exp=%b", k, irq, m_irq());
        errors++;
      end
    end
    address = 3'd3; #1;
    checks++;
    if (readdata !== 11'h001) begin
      $display("FAIL edgecap_set got=%h exp=%h", readdata, 11'h001);
      errors++;
    end
    bus_write(3'd3, 11'h001);
    checks++;
    if (irq !== 1'b0 || irq !== m_irq()) begin
      $display("FAIL irq_clear got=%b exp=0", irq);
      errors++;
    end
  endtask

  task automatic test_collision();
    bus_write(3'd2, 11'h000);
    in_port = 11'h005;
    repeat (LAT + 2) tick();
    in_port = 11'h001;
    repeat (LAT + 2) tick();
    in_port = 11'h005;
    repeat (LAT) tick();
    bus_write(3'd3, 11'h004);
    address = 3'd3; #1;
    checks++;
    if (readdata[2] !== 1'b1 || readdata !== m_read(3'd3)) begin
      $display("FAIL clear_vs_edge got=%h exp=%h", readdata, m_read(3'd3));
      errors++;
    end
    bus_write(3'd3, 11'h004);
    address = 3'd3; #1;
    checks++;
    if (readdata[2] !== 1'b0 || readdata !== m_read(3'd3)) begin
      $display("FAIL clear_only got=%h exp=%h", readdata, m_read(3'd3));
      errors++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      address = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom);
      write_n = 1'($urandom);
      writedata = W'($urandom);
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      #1;
      checks++;
      if (readdata !== m_read(address)) begin
        $display("FAIL rand_read n=%0d addr=%0d got=%h exp=%h", n, address, readdata, m_read(address));
        errors++;
      end
      tick();
      checks++;
      if (out_port !== m_dout || out_oe !== m_dir || irq !== m_irq()) begin
        $display("FAIL rand_outputs n=%0d out=%h/%h oe=%h/%h irq=%b/%b", n, out_port, m_dout, out_oe, m_dir, irq, m_irq());
        errors++;
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_async_reset();
    bus_write(3'd1, 11'h3FF);
    bus_write(3'd0, 11'h3FF);
    bus_write(3'd2, 11'h7FF);
    in_port = '0;
    repeat (LAT + 2) tick();
    in_port = 11'h400;
    repeat (LAT + 1) tick();
    checks++;
    if (irq !== 1'b1 || out_port !== 11'h3FF) begin
      $display("FAIL pre_reset irq=%b out=%h exp 1/3ff", irq, out_port);
      errors++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0 || out_port !== 11'h000 || out_oe !== 11'h000) begin
      $display("FAIL async_reset irq=%b out=%h oe=%h exp 0/000/000", irq, out_port, out_oe);
      errors++;
    end
    model_reset();
    in_port = '0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    address = 3'd3; #1;
    checks++;
    if (readdata !== 11'h000 || irq !== 1'b0) begin
      $display("FAIL post_reset edgecap=%h irq=%b exp 000/0", readdata, irq);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_set_clr();
    test_input();
    test_edge_irq();
    test_collision();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
